// File: rtl/sequential_divider.sv
// sequential_divider: iterative restoring divider, one quotient bit per clock.
// Shares the start/ready handshake of the shift-add multiplier.
// Optional feature: define DIVIDER_SIGNED_EN for two's-complement operands
// (truncating toward zero), which adds a one-cycle FIX state after RUN.
// Default build (macro undefined): unsigned operands and results.
module sequential_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

`ifdef DIVIDER_SIGNED_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd3
  } state_t;
`endif

  state_t r_state;
  state_t w_next;

  // Working registers: Q shifts the dividend out and quotient bits in;
  // the partial remainder is kept N bits wide because a committed
  // subtraction result always has a zero top bit.
  logic [N-1:0]     r_q;
  logic [N-1:0]     r_rem;
  logic [N-1:0]     r_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_zero;

  logic             r_ready;
  logic [N-1:0]     r_quotient;
  logic [N-1:0]     r_remainder;
  logic             r_dbz;

`ifdef DIVIDER_SIGNED_EN
  logic             r_neg_q;
  logic             r_neg_r;
`endif

  logic [N:0]       w_shift;
  logic [N:0]       w_diff;
  logic             w_fits;
  logic             w_div_zero;
  logic [N-1:0]     w_cap_q;
  logic [N-1:0]     w_cap_d;

`ifdef DIVIDER_SIGNED_EN
  // Two's-complement negation at operand width; -2^(N-1) maps to itself,
  // which read as unsigned is the correct magnitude 2^(N-1).
  function automatic logic [N-1:0] negate(input logic [N-1:0] v);
    return ~v + {{(N-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [N-1:0] magnitude(input logic [N-1:0] v);
    return v[N-1] ? negate(v) : v;
  endfunction
`endif

  assign w_shift    = {r_rem, r_q[N-1]};
  assign w_diff     = w_shift - {1'b0, r_d};
  assign w_fits     = ~w_diff[N];
  assign w_div_zero = (divisor == '0);

  // On divide-by-zero no iterations run, so Q simply carries the raw
  // dividend through to the remainder output.
`ifdef DIVIDER_SIGNED_EN
  assign w_cap_q = w_div_zero ? dividend : magnitude(dividend);
  assign w_cap_d = magnitude(divisor);
`else
  assign w_cap_q = dividend;
  assign w_cap_d = divisor;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_div_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_LAST) begin
`ifdef DIVIDER_SIGNED_EN
          w_next = S_FIX;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef DIVIDER_SIGNED_EN
      S_FIX:   w_next = S_DONE;
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state: busy covers the computing states only
  always_comb begin
    busy = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
`ifdef DIVIDER_SIGNED_EN
      S_FIX:   busy = 1'b1;
`endif
      default: busy = 1'b0;
    endcase
  end

  // Datapath: operand capture, one restoring step per RUN cycle,
  // sign fix-up, and result publication with the ready pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q         <= '0;
      r_rem       <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_zero      <= 1'b0;
      r_ready     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_q         <= w_cap_q;
            r_rem       <= '0;
            r_d         <= w_cap_d;
            r_cnt       <= '0;
            r_zero      <= w_div_zero;
`ifdef DIVIDER_SIGNED_EN
            r_neg_q     <= dividend[N-1] ^ divisor[N-1];
            r_neg_r     <= dividend[N-1];
`endif
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_fits) begin
            r_rem <= w_diff[N-1:0];
            r_q   <= {r_q[N-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[N-1:0];
            r_q   <= {r_q[N-2:0], 1'b0};
          end
        end
`ifdef DIVIDER_SIGNED_EN
        S_FIX: begin
          if (r_neg_q) begin
            r_q <= negate(r_q);
          end
          if (r_neg_r) begin
            r_rem <= negate(r_rem);
          end
        end
`endif
        S_DONE: begin
          r_ready <= 1'b1;
          if (r_zero) begin
            r_quotient  <= '1;
            r_remainder <= r_q;
            r_dbz       <= 1'b1;
          end else begin
            r_quotient  <= r_q;
            r_remainder <= r_rem;
            r_dbz       <= 1'b0;
          end
        end
        default: begin
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign ready       = r_ready;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_sequential_divider.sv
// tb_sequential_divider: randomized and directed checks of sequential_divider
// against a plain-arithmetic reference model (N = 4).
module tb_sequential_divider;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sequential_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .ready       (ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference: plain integer division of the operand values.
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] q, output logic [N-1:0] r,
                                output logic z);
`ifdef DIVIDER_SIGNED_EN
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      q = N'(sa / sb); r = N'(sa % sb); z = 1'b0;
    end
`else
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
`endif
  endfunction

  function automatic int exp_lat(input logic [N-1:0] b);
`ifdef DIVIDER_SIGNED_EN
    return (b == 0) ? 1 : N + 2;
`else
    return (b == 0) ? 1 : N + 1;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one division from the current cycle (#1 after an edge).
  // poke >= 0 re-asserts start with 9/4 in that cycle after the start edge.
  // b2b returns in the ready cycle so the caller can start immediately.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       input int poke, input bit b2b,
                       output logic [N-1:0] q, output logic [N-1:0] r, output logic z);
    logic [N-1:0] eq;
    logic [N-1:0] er;
    logic         ez;
    int lat;
    int pulses;
    int busy_n;
    bit seen;
    model(a, b, eq, er, ez);
    start = 1'b1; dividend = a; divisor = b;
    step();
    start = 1'b0; dividend = N'($urandom); divisor = N'($urandom);
    lat = -1; pulses = 0; busy_n = 0; seen = 1'b0;
    q = '0; r = '0; z = 1'b0;
    for (int k = 0; k < N + 6; k++) begin
      if (busy) busy_n++;
      if (ready) begin
        pulses++;
        if (!seen) begin
          seen = 1'b1; lat = k; q = quotient; r = remainder; z = div_by_zero;
        end
      end
      if (k == poke) begin
        start = 1'b1; dividend = N'(9); divisor = N'(4);
      end else begin
        start = 1'b0;
      end
      if (b2b && seen) break;
      step();
    end
    chk("latency", lat, exp_lat(b));
    chk("busy_cycles", busy_n, (b == 0) ? 0 : exp_lat(b) - 1);
    chk("quotient", q, eq);
    chk("remainder", r, er);
    chk("div_by_zero", z, ez);
    if (!b2b) begin
      chk("ready_pulses", pulses, 1);
      chk("hold_quotient", quotient, eq);
      chk("hold_remainder", remainder, er);
    end
  endtask

  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         z;
  int           idx [256];
  int           pulses;

  initial begin
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);

`ifdef DIVIDER_SIGNED_EN
    do_op(4'h9, 4'h2, -1, 1'b0, q, r, z);
    chk("s_m7_2_q", q, 4'hD);
    chk("s_m7_2_r", r, 4'hF);
    do_op(4'h7, 4'hE, -1, 1'b0, q, r, z);
    chk("s_7_m2_q", q, 4'hD);
    chk("s_7_m2_r", r, 4'h1);
    do_op(4'h8, 4'hF, -1, 1'b0, q, r, z);
    chk("s_ovf_q", q, 4'h8);
    chk("s_ovf_r", r, 4'h0);
    chk("s_ovf_dbz", z, 0);
`else
    do_op(4'd13, 4'd3, -1, 1'b0, q, r, z);
    chk("d13_3_q", q, 4);
    chk("d13_3_r", r, 1);
    chk("d13_3_dbz", z, 0);
    do_op(4'd15, 4'd1, -1, 1'b0, q, r, z);
    chk("d15_1_q", q, 15);
    chk("d15_1_r", r, 0);
    do_op(4'd3, 4'd7, -1, 1'b0, q, r, z);
    chk("d3_7_q", q, 0);
    chk("d3_7_r", r, 3);
    do_op(4'd0, 4'd5, -1, 1'b0, q, r, z);
    chk("d0_5_q", q, 0);
    chk("d0_5_r", r, 0);
    do_op(4'd5, 4'd0, -1, 1'b0, q, r, z);
    chk("d5_0_q", q, 4'hF);
    chk("d5_0_r", r, 5);
    chk("d5_0_dbz", z, 1);
    do_op(4'd6, 4'd2, -1, 1'b0, q, r, z);
    chk("d6_2_q", q, 3);
    chk("d6_2_dbz", z, 0);
`endif

    // start re-asserted during RUN and during DONE must be ignored
    do_op(4'd13, 4'd3, 1, 1'b0, q, r, z);
    do_op(4'd13, 4'd3, exp_lat(4'd3) - 1, 1'b0, q, r, z);
    do_op(4'd11, 4'd0, 0, 1'b0, q, r, z);

    // Reset pulse mid-RUN aborts silently
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    step();
    start = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_ready", ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    pulses = 0;
    for (int k = 0; k < N + 4; k++) begin
      if (ready) pulses++;
      step();
    end
    chk("abort_no_ready", pulses, 0);
    do_op(4'd14, 4'd4, -1, 1'b0, q, r, z);

    // Back-to-back: each new start lands in the ready cycle of the previous
    for (int i = 0; i < 8; i++) begin
      do_op(N'($urandom), N'($urandom_range(0, 15)), -1, 1'b1, q, r, z);
    end
    step(); step();

    // Every operand pair, in a random order
    for (int i = 0; i < 256; i++) idx[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(0, i));
      t = idx[i]; idx[i] = idx[j]; idx[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      do_op(N'(idx[i] >> N), N'(idx[i]), -1, 1'b0, q, r, z);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
